// File: rtl/db4_pkg.sv
// db4_pkg -- shared constants, types and output scaling for the DB4 interpolator.
//
// Contents:
//   IN_W / ACC_W / OUT_W  sample, accumulator and output widths
//   TAP_F0..TAP_F3        synthesis lowpass taps f = [-33, 57, 214, 124], scale 256
//   state_e               interpolator FSM states
//   scale_out()           drops the 8 fractional bits of an accumulator
//
// Build option: define DB4INTERP_ROUND_EN to round half up before the shift;
// without it the result is floored by the arithmetic shift.
package db4_pkg;

   localparam int unsigned IN_W   = 8;
   localparam int unsigned ACC_W  = 17;
   localparam int unsigned OUT_W  = 9;
   localparam int unsigned FRAC_W = 8;

   localparam int TAP_F0 = -33;
   localparam int TAP_F1 = 57;
   localparam int TAP_F2 = 214;
   localparam int TAP_F3 = 124;

   localparam int ROUND_HALF = 128;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EVEN = 2'd1,
      S_ODD  = 2'd2
   } state_e;

   // The accumulator range (about +/-31.6k) leaves headroom for the rounding
   // offset and lands inside OUT_W bits after the shift.
   function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] adj;
`ifdef DB4INTERP_ROUND_EN
      adj = acc + ACC_W'(ROUND_HALF);
`else
      adj = acc;
`endif
      return OUT_W'(adj >>> FRAC_W);
   endfunction

endpackage

// File: rtl/db4interp_rag.sv
// db4interp_rag -- multiplierless polyphase products for the DB4 interpolator.
//
// Ports:
//   x_cur   in   IN_W   newest accepted sample
//   x_prev  in   IN_W   previous accepted sample
//   e       out  ACC_W  even branch  -33*x_cur + 214*x_prev
//   o       out  ACC_W  odd branch    57*x_cur + 124*x_prev
//
// Every product is a shift-add chain; no multipliers are inferred.
module db4interp_rag
   import db4_pkg::*;
(
   input  logic signed [IN_W-1:0]  x_cur,
   input  logic signed [IN_W-1:0]  x_prev,
   output logic signed [ACC_W-1:0] e,
   output logic signed [ACC_W-1:0] o
);

   logic signed [ACC_W-1:0] xc;
   logic signed [ACC_W-1:0] xp;
   logic signed [ACC_W-1:0] c33;
   logic signed [ACC_W-1:0] c57;
   logic signed [ACC_W-1:0] p107;
   logic signed [ACC_W-1:0] p214;
   logic signed [ACC_W-1:0] p124;

   always_comb begin
      xc = {{(ACC_W-IN_W){x_cur[IN_W-1]}}, x_cur};
      xp = {{(ACC_W-IN_W){x_prev[IN_W-1]}}, x_prev};

      // 33 = 32 + 1
      c33  = (xc <<< 5) + xc;
      // 57 = 64 - 8 + 1
      c57  = (xc <<< 6) - (xc <<< 3) + xc;
      // 107 = 99 + 8, with 99 = 64 + 32 + 2 + 1
      p107 = (xp <<< 6) + (xp <<< 5) + (xp <<< 1) + xp + (xp <<< 3);
      p214 = p107 <<< 1;
      // 124 = 128 - 4
      p124 = (xp <<< 7) - (xp <<< 2);

      e = p214 - c33;
      o = c57 + p124;
   end

endmodule

// File: rtl/db4interp.sv
// db4interp -- DB4 synthesis lowpass, upsample-by-2 interpolator.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous active-low reset
//   x_in      in   8      signed low-band sample
//   x_valid   in   1      x_in holds a valid sample
//   x_ready   out  1      a sample can be accepted this cycle
//   y_out     out  9      signed interpolated sample, registered
//   y_valid   out  1      y_out valid this cycle
//   y_phase   out  1      branch of y_out: 0 = even (G0), 1 = odd (G1)
//   underrun  out  1      one-cycle pulse when the output stream breaks
//
// Each accepted sample produces an even output then an odd output on the two
// following edges. Accepting again while the odd output leaves keeps y_valid
// high continuously; otherwise the FSM drops to idle and flags an underrun.
// Build option: DB4INTERP_ROUND_EN selects round-half-up instead of floor.
module db4interp
   import db4_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [IN_W-1:0]  x_in,
   input  logic                    x_valid,
   output logic                    x_ready,
   output logic signed [OUT_W-1:0] y_out,
   output logic                    y_valid,
   output logic                    y_phase,
   output logic                    underrun
);

   state_e state_q, state_d;

   logic signed [IN_W-1:0]  x_cur_q;
   logic signed [IN_W-1:0]  x_prev_q;
   logic signed [OUT_W-1:0] y_q, y_d;
   logic                    y_valid_q, y_valid_d;
   logic                    y_phase_q, y_phase_d;
   logic                    underrun_q, underrun_d;
   logic                    accept;

   logic signed [ACC_W-1:0] e_acc;
   logic signed [ACC_W-1:0] o_acc;

   db4interp_rag u_rag (
      .x_cur  (x_cur_q),
      .x_prev (x_prev_q),
      .e      (e_acc),
      .o      (o_acc)
   );

   always_comb begin
      state_d    = state_q;
      x_ready    = 1'b0;
      accept     = 1'b0;
      y_d        = y_q;
      y_valid_d  = 1'b0;
      y_phase_d  = y_phase_q;
      underrun_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            x_ready = 1'b1;
            if (x_valid) begin
               accept  = 1'b1;
               state_d = S_EVEN;
            end
         end
         S_EVEN: begin
            state_d   = S_ODD;
            y_d       = scale_out(e_acc);
            y_valid_d = 1'b1;
            y_phase_d = 1'b0;
         end
         S_ODD: begin
            x_ready   = 1'b1;
            // o_acc still uses the pair that produced the even output; the
            // history update on accept lands at the same edge.
            y_d       = scale_out(o_acc);
            y_valid_d = 1'b1;
            y_phase_d = 1'b1;
            if (x_valid) begin
               accept  = 1'b1;
               state_d = S_EVEN;
            end else begin
               state_d    = S_IDLE;
               underrun_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         x_cur_q    <= '0;
         x_prev_q   <= '0;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         y_phase_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
         y_phase_q  <= y_phase_d;
         underrun_q <= underrun_d;
         // History survives idle gaps; only reset clears it.
         if (accept) begin
            x_prev_q <= x_cur_q;
            x_cur_q  <= x_in;
         end
      end
   end

   assign y_out    = y_q;
   assign y_valid  = y_valid_q;
   assign y_phase  = y_phase_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_db4interp.sv
`timescale 1ns/1ps
module tb_db4interp;

   logic              clk = 1'b0;
   logic              reset;
   logic signed [7:0] x_in;
   logic              x_valid;
   logic              x_ready;
   logic signed [8:0] y_out;
   logic              y_valid;
   logic              y_phase;
   logic              underrun;

   db4interp dut (
      .clk      (clk),
      .reset    (reset),
      .x_in     (x_in),
      .x_valid  (x_valid),
      .x_ready  (x_ready),
      .y_out    (y_out),
      .y_valid  (y_valid),
      .y_phase  (y_phase),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

`ifdef DB4INTERP_ROUND_EN
   localparam int IMP_E1 = 84;
   localparam int DC_POS = 90;
   localparam int DC_NEG = -90;
   localparam int HIST_E = 42;
`else
   localparam int IMP_E1 = 83;
   localparam int DC_POS = 89;
   localparam int DC_NEG = -91;
   localparam int HIST_E = 41;
`endif
   localparam int HIST_O = 24;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int   y;
      logic ph;
   } exp_t;

   exp_t sb[$];
   exp_t mon_ex;
   int   seen_y[$];
   logic seen_p[$];
   int   y_cnt  = 0;
   int   ur_cnt = 0;

   // Reference model: handshake state, history and expected output flags.
   int   m_state = 0;  // 0 idle, 1 even, 2 odd
   int   m_cur   = 0;
   logic m_ur    = 1'b0;
   logic m_yv    = 1'b0;

   function automatic int scale(input int acc);
`ifdef DB4INTERP_ROUND_EN
      return (acc + 128) >>> 8;
`else
      return acc >>> 8;
`endif
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state <= 0;
         m_cur   <= 0;
         m_ur    <= 1'b0;
         m_yv    <= 1'b0;
         sb.delete();
      end else begin
         m_ur <= 1'b0;
         m_yv <= (m_state == 1) || (m_state == 2);
         if (x_valid === 1'b1 && m_state != 1) begin
            sb.push_back('{scale(-33 * int'(x_in) + 214 * m_cur), 1'b0});
            sb.push_back('{scale(57 * int'(x_in) + 124 * m_cur), 1'b1});
            m_cur   <= int'(x_in);
            m_state <= 1;
         end else if (m_state == 1) begin
            m_state <= 2;
         end else begin
            if (m_state == 2) m_ur <= 1'b1;
            m_state <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         n_chk++;
         if (x_ready !== (m_state != 1))
            $display("FAIL x_ready: got %b want %b", x_ready, (m_state != 1));
         else n_pass++;
         n_chk++;
         if (underrun !== m_ur) $display("FAIL underrun: got %b want %b", underrun, m_ur);
         else n_pass++;
         n_chk++;
         if (y_valid !== m_yv) $display("FAIL y_valid: got %b want %b", y_valid, m_yv);
         else n_pass++;
         if (underrun === 1'b1) ur_cnt++;
         if (y_valid === 1'b1) begin
            y_cnt++;
            seen_y.push_back(int'(y_out));
            seen_p.push_back(y_phase);
            n_chk++;
            if (sb.size() == 0) begin
               $display("FAIL scoreboard: y_out %0d with nothing pending", y_out);
            end else begin
               mon_ex = sb.pop_front();
               if (int'(y_out) != mon_ex.y || y_phase !== mon_ex.ph)
                  $display("FAIL scoreboard: got y_out %0d phase %b want %0d phase %b",
                           y_out, y_phase, mon_ex.y, mon_ex.ph);
               else n_pass++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int val);
      logic took = 1'b0;
      x_in    = 8'(val);
      x_valid = 1'b1;
      for (int i = 0; i < 4 && !took; i++) begin
         took = x_ready;
         @(posedge clk);
         #1;
      end
      n_chk++;
      if (!took) $display("FAIL send: sample %0d not accepted within 4 cycles", val);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      x_valid = 1'b1;
      x_in    = 8'sd55;
      tick(3);
      n_chk++; if (y_out !== 9'sd0) $display("FAIL reset y_out: got %0d want 0", y_out);
      else n_pass++;
      n_chk++; if (y_valid !== 1'b0) $display("FAIL reset y_valid: got %b want 0", y_valid);
      else n_pass++;
      n_chk++; if (y_phase !== 1'b0) $display("FAIL reset y_phase: got %b want 0", y_phase);
      else n_pass++;
      n_chk++; if (underrun !== 1'b0) $display("FAIL reset underrun: got %b want 0", underrun);
      else n_pass++;
      n_chk++; if (x_ready !== 1'b1) $display("FAIL reset x_ready: got %b want 1", x_ready);
      else n_pass++;
      x_valid = 1'b0;
      reset   = 1'b1;
      y_cnt   = 0;
      tick(4);
      n_chk++; if (y_cnt != 0) $display("FAIL reset no_accept: got %0d outputs want 0", y_cnt);
      else n_pass++;
   endtask

   task automatic test_impulse();
      int exp_y[6];
      exp_y = '{-13, 22, IMP_E1, 48, 0, 0};
      seen_y.delete();
      seen_p.delete();
      send(100);
      send(0);
      send(0);
      x_valid = 1'b0;
      tick(4);
      n_chk++;
      if (seen_y.size() != 6) $display("FAIL impulse count: got %0d want 6", seen_y.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (i >= seen_y.size())
            $display("FAIL impulse[%0d]: got nothing want %0d", i, exp_y[i]);
         else if (seen_y[i] != exp_y[i] || seen_p[i] !== 1'(i % 2))
            $display("FAIL impulse[%0d]: got %0d phase %b want %0d phase %0d",
                     i, seen_y[i], seen_p[i], exp_y[i], i % 2);
         else n_pass++;
      end
   endtask

   task automatic test_dc(input int val, input int expv);
      x_in    = 8'(val);
      x_valid = 1'b1;
      tick(4);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_chk++;
         if (y_valid !== 1'b1 || int'(y_out) != expv)
            $display("FAIL dc %0d cycle %0d: got valid %b y_out %0d want valid 1 y_out %0d",
                     val, i, y_valid, y_out, expv);
         else n_pass++;
      end
      tick(2);
      x_valid = 1'b0;
      tick(6);
   endtask

   task automatic test_underrun();
      y_cnt  = 0;
      ur_cnt = 0;
      send(50);
      x_valid = 1'b0;
      tick(6);
      n_chk++; if (y_cnt != 2) $display("FAIL underrun outputs: got %0d want 2", y_cnt);
      else n_pass++;
      n_chk++; if (ur_cnt != 1) $display("FAIL underrun pulses: got %0d want 1", ur_cnt);
      else n_pass++;
      n_chk++; if (x_ready !== 1'b1) $display("FAIL underrun idle x_ready: got %b want 1", x_ready);
      else n_pass++;
      // History from before the gap must feed the next pair.
      seen_y.delete();
      seen_p.delete();
      send(0);
      x_valid = 1'b0;
      tick(4);
      n_chk++;
      if (seen_y.size() != 2 || seen_y[0] != HIST_E || seen_y[1] != HIST_O)
         $display("FAIL history: got %0d values first %0d want %0d,%0d", seen_y.size(),
                  (seen_y.size() > 0) ? seen_y[0] : 0, HIST_E, HIST_O);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int   acc = 0;
      logic rdy;
      y_cnt   = 0;
      x_in    = 8'sd20;
      x_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rdy = x_ready;
         n_chk++;
         if (rdy !== (i % 2 == 0))
            $display("FAIL backpressure x_ready[%0d]: got %b want %b", i, rdy, (i % 2 == 0));
         else n_pass++;
         if (rdy === 1'b1) acc++;
         @(posedge clk);
         #1;
         if (rdy === 1'b1) x_in = 8'(13 * i - 60);
      end
      x_valid = 1'b0;
      tick(5);
      n_chk++; if (acc != 5) $display("FAIL backpressure accepts: got %0d want 5", acc);
      else n_pass++;
      n_chk++; if (y_cnt != 10) $display("FAIL backpressure outputs: got %0d want 10", y_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      send(10);
      x_in    = 8'sd30;
      x_valid = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      n_chk++; if (y_out !== 9'sd0) $display("FAIL midreset y_out: got %0d want 0", y_out);
      else n_pass++;
      n_chk++; if (y_valid !== 1'b0) $display("FAIL midreset y_valid: got %b want 0", y_valid);
      else n_pass++;
      n_chk++; if (y_phase !== 1'b0) $display("FAIL midreset y_phase: got %b want 0", y_phase);
      else n_pass++;
      n_chk++; if (underrun !== 1'b0) $display("FAIL midreset underrun: got %b want 0", underrun);
      else n_pass++;
      n_chk++; if (x_ready !== 1'b1) $display("FAIL midreset x_ready: got %b want 1", x_ready);
      else n_pass++;
      x_valid = 1'b0;
      tick(2);
      reset = 1'b1;
      y_cnt = 0;
      tick(4);
      n_chk++; if (y_cnt != 0) $display("FAIL midreset aborted: got %0d outputs want 0", y_cnt);
      else n_pass++;
      test_impulse();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset   = 1'b0;
      x_valid = 1'b0;
      x_in    = 8'sd0;
      test_reset();
      test_impulse();
      test_dc(127, DC_POS);
      test_dc(-128, DC_NEG);
      test_underrun();
      test_backpressure();
      test_reset_mid();
      n_chk++;
      if (sb.size() != 0) $display("FAIL drain: got %0d pending want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
